// File: rtl/pkt_fwd_ctrl_pkg.sv
// Shared definitions for the forwarder-side sequencer.
//   - FSM state encodings (3-bit, legacy-compatible constants)
//   - clog2_min1: width helper that never returns 0 (for small counters)
package pkt_fwd_ctrl_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 3'd1;
  localparam logic [ST_W-1:0] ST_LEN  = 3'd2;
  localparam logic [ST_W-1:0] ST_XFER = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE = 3'd4;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fwd_out_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write one word (ignored when full unless a pop happens too)
//   pop      : drop the head word (ignored when empty)
//   dout     : current head word, valid whenever !empty
//   empty, full, count : status and occupancy
module fwd_out_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push-while-full is legal then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pkt_fwd_ctrl.sv
// Forwarder-side sequencer for the forward arbiter.
// Claims a ready core (rdy/ack), samples byte_len, reads the packet words
// from address 0 upward into a credit-controlled FIFO and streams them out
// as AXI-Stream, then pulses done to release the core's buffer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy, ack            core-available / grant; transfer on rdy && ack
//   byte_len            packet length in bytes of the granted core
//   addr, rd_en         word read request, one per cycle
//   rd_data, rd_data_vld read return, in order, one per rd_en
//   m_t*                AXI-Stream master (beat moves on m_tvalid && m_tready;
//                       m_tvalid/m_tdata never depend on m_tready)
//   done                1-cycle release pulse after the last beat
//   len_err             1-cycle pulse when the packet is truncated to MAXW words
//   state_dbg           current FSM state
module pkt_fwd_ctrl
  import pkt_fwd_ctrl_pkg::*;
#(
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH        = 32,
  parameter int MUX_LAT           = 0,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [SN_FWD_ADDR_WIDTH-1:0]   addr,
  output logic                           rd_en,
  input  logic [SN_FWD_DATA_WIDTH-1:0]   rd_data,
  input  logic                           rd_data_vld,
  input  logic [PLEN_WIDTH-1:0]          byte_len,
  output logic                           done,
  input  logic                           rdy,
  output logic                           ack,
  output logic [SN_FWD_DATA_WIDTH-1:0]   m_tdata,
  output logic [SN_FWD_DATA_WIDTH/8-1:0] m_tkeep,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           len_err,
  output logic [ST_W-1:0]                state_dbg
);

  localparam int AW    = SN_FWD_ADDR_WIDTH;
  localparam int DW    = SN_FWD_DATA_WIDTH;
  localparam int KW    = DW / 8;
  localparam int LB    = $clog2(KW);
  localparam int CW    = $clog2(FIFO_DEPTH);
  localparam int WCW   = clog2_min1(MUX_LAT + 1);
  localparam logic [AW:0] MAXW = {1'b1, {AW{1'b0}}};

  logic [ST_W-1:0]       state;
  logic [ST_W-1:0]       state_nxt;
  logic [WCW-1:0]        wait_cnt;
  logic [AW:0]           words;
  logic [AW:0]           issued;
  logic [AW:0]           sent;
  logic [KW-1:0]         last_keep;
  logic [CW:0]           outstanding;

  logic [CW:0]           occ;
  logic                  f_empty;
  logic                  f_full;
  logic [DW-1:0]         f_dout;

  logic [PLEN_WIDTH:0]   words_raw;
  logic [PLEN_WIDTH-1:0] rem;
  logic                  over;
  logic [AW:0]           words_dec;
  logic [KW-1:0]         keep_dec;

  logic                  xfer;
  logic                  rsp;
  logic                  push;
  logic                  pop;
  logic                  is_last;
  logic                  credit_ok;
  logic [CW+1:0]         in_use;

  assign state_dbg = state;

  // Length decode; one extra bit so byte_len near 2^PLEN_WIDTH cannot wrap.
  always_comb begin
    words_raw = ({1'b0, byte_len} + (PLEN_WIDTH+1)'(KW - 1)) >> LB;
    rem       = byte_len & PLEN_WIDTH'(KW - 1);
    over      = words_raw > (PLEN_WIDTH+1)'(MAXW);
    words_dec = over ? MAXW : words_raw[AW:0];
    // A truncated packet ends on a full word, whatever the remainder says.
    keep_dec  = (rem == '0 || over) ? '1 : ((KW'(1) << rem) - KW'(1));
  end

  // Credits cover both words already buffered and reads still in flight.
  assign in_use    = {1'b0, occ} + {1'b0, outstanding};
  assign credit_ok = in_use < (CW+2)'(FIFO_DEPTH);

  assign xfer    = (state == ST_XFER);
  assign rd_en   = xfer && (issued < words) && credit_ok;
  assign addr    = issued[AW-1:0];
  assign rsp     = xfer && rd_data_vld;
  assign push    = rsp && !f_full;
  assign is_last = (sent == words - (AW+1)'(1));

  assign m_tvalid = xfer && !f_empty;
  assign m_tdata  = m_tvalid ? f_dout : '0;
  assign m_tlast  = m_tvalid && is_last;
  assign m_tkeep  = m_tvalid ? (is_last ? last_keep : '1) : '0;
  assign pop      = m_tvalid && m_tready;

  assign done    = (state == ST_DONE);
  assign len_err = (state == ST_LEN) && over;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rdy && ack) state_nxt = ST_WAIT;
      ST_WAIT: if (wait_cnt == WCW'(MUX_LAT)) state_nxt = ST_LEN;
      ST_LEN:  state_nxt = (words_dec == '0) ? ST_DONE : ST_XFER;
      ST_XFER: if (pop && is_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ack         <= 1'b0;
      wait_cnt    <= '0;
      words       <= '0;
      last_keep   <= '0;
      issued      <= '0;
      sent        <= '0;
      outstanding <= '0;
    end else begin
      state <= state_nxt;
      // Registered grant: high in every IDLE cycle except right after reset,
      // drops the cycle after the handshake.
      ack   <= (state_nxt == ST_IDLE);
      case (state)
        ST_WAIT: wait_cnt <= wait_cnt + 1'b1;
        ST_LEN: begin
          words       <= words_dec;
          last_keep   <= keep_dec;
          issued      <= '0;
          sent        <= '0;
          outstanding <= '0;
        end
        ST_XFER: begin
          if (rd_en) issued <= issued + 1'b1;
          if (pop)   sent   <= sent + 1'b1;
          case ({rd_en, rsp})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: ;
          endcase
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  fwd_out_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rd_data),
    .pop   (pop),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (f_full),
    .count (occ)
  );

endmodule

// File: tb/tb_pkt_fwd_ctrl.sv
// Testbench for pkt_fwd_ctrl (default parameters, 1-cycle read latency).
module tb_pkt_fwd_ctrl;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int PW = 32;
  localparam int KW = DW / 8;
  localparam int BW = DW + KW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_data_vld;
  logic [PW-1:0] byte_len;
  logic          done;
  logic          rdy;
  logic          ack;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic          len_err;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pkt_fwd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld),
    .byte_len    (byte_len),
    .done        (done),
    .rdy         (rdy),
    .ack         (ack),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tlast     (m_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .len_err     (len_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] pkt_tag = 8'h00;
  int hs_cyc, rd_cnt, first_rd_cyc, done_cnt, done_cyc, len_err_cnt, last_beat_cyc;
  logic [AW-1:0] rd_addr_q[$];
  logic [BW-1:0] got_q[$];
  logic [BW-1:0] exp_q[$];

  function automatic logic [DW-1:0] mk_data(input logic [7:0] tag, input logic [AW-1:0] a);
    return {16'hBEEF, tag, 8'hC3, 16'h0000, ~a, a};
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder (1-cycle latency) ----------------
  initial begin : responder
    logic          seen_rd;
    logic          seen_rst;
    logic [AW-1:0] seen_addr;
    rd_data_vld = 1'b0;
    rd_data     = '0;
    forever begin
      @(negedge clk);
      seen_rd   = rd_en;
      seen_rst  = rst;
      seen_addr = addr;
      @(posedge clk);
      #1;
      rd_data_vld = seen_rd && !seen_rst;
      rd_data     = mk_data(pkt_tag, seen_addr);
    end
  end

  // ---------------- monitor (samples at negedge) ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_en) begin
          if (rd_cnt == 0) first_rd_cyc = cyc;
          rd_cnt++;
          rd_addr_q.push_back(addr);
        end
        if (m_tvalid && m_tready) begin
          got_q.push_back({m_tdata, m_tkeep, m_tlast});
          last_beat_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (len_err) len_err_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    rd_cnt = 0; first_rd_cyc = -1; done_cnt = 0; done_cyc = -1;
    len_err_cnt = 0; last_beat_cyc = -1;
    rd_addr_q.delete(); got_q.delete(); exp_q.delete();
  endtask

  // Called at posedge+1; returns just after the negedge following the handshake.
  task automatic start_pkt(input logic [PW-1:0] len);
    int n = 0;
    byte_len = len;
    rdy = 1'b1;
    @(negedge clk);
    while (!ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_int("handshake_ack", int'(ack), 1);
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    @(negedge clk);
    check_int("ack_drop", int'(ack), 0);
  endtask

  // mode 0: m_tready held high; mode 1: m_tready throttled randomly.
  task automatic wait_done(input int mode);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      #1;
      m_tready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      n++;
    end
    check_int("done_timeout", int'(n < 3000), 1);
    repeat (3) @(posedge clk);
    #1;
    m_tready = 1'b1;
  endtask

  task automatic cmp_pkt(input int words, input logic [KW-1:0] keep, input int err);
    logic [BW-1:0] g;
    logic [BW-1:0] e;
    for (int i = 0; i < words; i++) begin
      exp_q.push_back({mk_data(pkt_tag, AW'(i)),
                       (i == words - 1) ? keep : {KW{1'b1}},
                       (i == words - 1)});
    end
    check_int("rd_count", rd_cnt, words);
    check_int("beat_count", got_q.size(), words);
    for (int i = 0; i < rd_addr_q.size(); i++)
      check_int("rd_addr", int'(rd_addr_q[i]), i);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      check_vec("beat", g, e);
    end
    check_int("done_pulses", done_cnt, 1);
    check_int("len_err_pulses", len_err_cnt, err);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [PW-1:0] len;
    int            mode;
    int            words;
    logic [KW-1:0] keep;
    int            err;
  } vec_t;

  vec_t vecs[10];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{32'd20,   0, 3,   8'h0F, 0};
    vecs[1] = '{32'd16,   0, 2,   8'hFF, 0};
    vecs[2] = '{32'd8,    1, 1,   8'hFF, 0};
    vecs[3] = '{32'd1,    0, 1,   8'h01, 0};
    vecs[4] = '{32'd61,   1, 8,   8'h1F, 0};
    vecs[5] = '{32'd200,  1, 25,  8'hFF, 0};
    vecs[6] = '{32'd2048, 0, 256, 8'hFF, 0};
    vecs[7] = '{32'd2049, 1, 256, 8'hFF, 1};
    vecs[8] = '{32'd3000, 0, 256, 8'hFF, 1};
    vecs[9] = '{32'd0,    0, 0,   8'hFF, 0};

    rst = 1'b1; rdy = 1'b0; byte_len = '0; m_tready = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check_int("rst_ack", int'(ack), 0);
    check_int("rst_rd_en", int'(rd_en), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_tvalid", int'(m_tvalid), 0);
    check_int("rst_tlast", int'(m_tlast), 0);
    check_int("rst_len_err", int'(len_err), 0);
    check_int("rst_addr", int'(addr), 0);
    check_int("rst_tkeep", int'(m_tkeep), 0);
    check_vec("rst_tdata", BW'(m_tdata), '0);
    check_int("rst_state", int'(state_dbg), 0);
    @(negedge clk);
    check_int("ack_after_rst", int'(ack), 1);
    @(posedge clk);
    #1;

    // 20 bytes: handshake-to-read latency and done one cycle after last beat.
    clear_mon(); pkt_tag = 8'h11;
    start_pkt(32'd20);
    wait_done(0);
    check_int("first_rd_latency", first_rd_cyc - hs_cyc, 3);
    check_int("done_after_last", done_cyc - last_beat_cyc, 1);
    cmp_pkt(3, 8'h0F, 0);

    // Zero length: no reads, done 1+MUX_LAT+2 cycles after the handshake.
    clear_mon(); pkt_tag = 8'h22;
    start_pkt(32'd0);
    wait_done(0);
    check_int("len0_done_time", done_cyc - hs_cyc, 3);
    check_int("len0_reads", rd_cnt, 0);
    check_int("len0_beats", got_q.size(), 0);

    // Back-pressure: credits stop reads at FIFO_DEPTH.
    clear_mon(); pkt_tag = 8'h33;
    m_tready = 1'b0;
    start_pkt(32'd200);
    repeat (30) @(posedge clk);
    #1;
    check_int("stall_reads", rd_cnt, 8);
    check_int("stall_beats", got_q.size(), 0);
    wait_done(0);
    cmp_pkt(25, 8'hFF, 0);

    // Reset in the middle of a transfer.
    clear_mon(); pkt_tag = 8'h44;
    begin
      int n = 0;
      start_pkt(32'd200);
      while (got_q.size() < 5 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      check_int("beats_before_rst", got_q.size(), 5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_int("abort_ack", int'(ack), 0);
      check_int("abort_rd_en", int'(rd_en), 0);
      check_int("abort_done", int'(done), 0);
      check_int("abort_tvalid", int'(m_tvalid), 0);
      check_int("abort_tlast", int'(m_tlast), 0);
      check_int("abort_addr", int'(addr), 0);
      check_int("abort_tkeep", int'(m_tkeep), 0);
      check_vec("abort_tdata", BW'(m_tdata), '0);
      check_int("abort_state", int'(state_dbg), 0);
      clear_mon();
      repeat (4) @(posedge clk);
      #1;
      check_int("abort_no_done", done_cnt, 0);
      clear_mon(); pkt_tag = 8'h55;
      start_pkt(32'd20);
      wait_done(0);
      cmp_pkt(3, 8'h0F, 0);
    end

    // Table-driven packets.
    for (int v = 0; v < 10; v++) begin
      clear_mon();
      pkt_tag = 8'h60 + 8'(v);
      start_pkt(vecs[v].len);
      wait_done(vecs[v].mode);
      cmp_pkt(vecs[v].words, vecs[v].keep, vecs[v].err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
